// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shifts and shift-add multiply.
// Operands arrive and results leave through valid/ready handshakes.
//   state | meaning
//   IDLE  | ready for a new operation
//   BUSY  | iterating a shift or multiply, counter counts down to zero
//   DONE  | result/flags presented, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             cout_f,
  output logic             over_f
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, cout_q, cout_d, over_q, over_d;

  logic [WIDTH:0]     sum, diff;
  logic               add_ovf, sub_ovf;
  logic [WIDTH-1:0]   sh_step, res;
  logic [2*WIDTH-1:0] acc_step;
  logic               c, v;
  logic               is_mul;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // sh_q is the shift operand for shifts and the remaining multiplier bits for MUL
  assign is_mul   = (op_q[1:0] == 2'b11);
  assign acc_step = sh_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    case (op_q[1:0])
      2'b00:   sh_step = {sh_q[WIDTH-2:0], 1'b0};
      2'b01:   sh_step = {1'b0, sh_q[WIDTH-1:1]};
      2'b10:   sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_step = sh_q;
    endcase
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero_f    = zero_q;
  assign cout_f    = cout_q;
  assign over_f    = over_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    over_d   = over_q;
    res      = '0;
    c        = 1'b0;
    v        = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d = op;
          if (op[3:2] == 2'b10) begin
            sh_d    = (op[1:0] == 2'b11) ? b : a;
            mcand_d = {{WIDTH{1'b0}}, a};
            acc_d   = '0;
            cnt_d   = (op[1:0] == 2'b11) ? CW'(WIDTH) : {1'b0, b[SW-1:0]};
            if (op[1:0] != 2'b11 && b[SW-1:0] == '0) begin
              result_d = a;
              zero_d   = (a == '0);
              cout_d   = 1'b0;
              over_d   = 1'b0;
              state_d  = DONE;
            end else begin
              state_d = BUSY;
            end
          end else begin
            case (op)
              4'b0000: begin res = sum[WIDTH-1:0];  c = sum[WIDTH];  v = add_ovf; end
              4'b0001: begin res = diff[WIDTH-1:0]; c = diff[WIDTH]; v = sub_ovf; end
              4'b0010: res = ~a;
              4'b0011: res = a & b;
              4'b0100: res = a | b;
              4'b0101: res = a ^ b;
              4'b0110: begin
                res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
                c   = diff[WIDTH];
                v   = sub_ovf;
              end
              4'b0111: res = {{(WIDTH-1){1'b0}}, (a == b)};
              default: res = '0;
            endcase
            result_d = res;
            zero_d   = (res == '0);
            cout_d   = c;
            over_d   = v;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (is_mul) begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          sh_d    = sh_q >> 1;
        end else begin
          sh_d = sh_step;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (is_mul) begin
            result_d = acc_step[WIDTH-1:0];
            zero_d   = (acc_step[WIDTH-1:0] == '0);
            cout_d   = (acc_step[2*WIDTH-1:WIDTH] != '0);
            over_d   = (acc_step[2*WIDTH-1:WIDTH] != '0);
          end else begin
            result_d = sh_step;
            zero_d   = (sh_step == '0);
            cout_d   = 1'b0;
            over_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      over_q   <= over_d;
    end
  end
endmodule
